// File: rtl/ip_prefetch_queue.sv
// Instruction prefetch stage: fetches single words at the current IP and queues them, tagged with
// their address, for the decoder. A flush empties the queue and discards the fetch in flight.
module ip_prefetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int CW    = 3
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic [AW-1:0] ip_addr,
   output logic          ip_oe,
   output logic          ip_inc,
   input  logic          flush,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic          dec_valid,
   output logic [DW-1:0] dec_instr,
   output logic [AW-1:0] dec_addr,
   input  logic          dec_ready,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t          state_reg, state_next;
   logic            mem_req_reg;
   logic [AW-1:0]   mem_addr_reg;
   logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [DW-1:0]   instr_mem [DEPTH];
   logic [AW-1:0]   addr_mem  [DEPTH];
   logic            issue, push, pop;

   always_ff @(posedge Clk) begin
      if (!Reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (issue) state_next = REQ;
         REQ: begin
            if (mem_ack)    state_next = IDLE;
            else if (flush) state_next = DISCARD;
         end
         DISCARD: if (mem_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A request is only launched with a free slot, so the eventual push cannot overflow.
   always_comb begin
      ip_oe  = (state_reg == IDLE);
      issue  = (state_reg == IDLE) && !flush && (count_reg < CW'(DEPTH));
      push   = Reset && (state_reg == REQ) && mem_ack && !flush;
      ip_inc = push;
   end

   assign pop       = (count_reg != '0) && dec_ready && !flush;
   assign dec_valid = (count_reg != '0);
   assign dec_instr = instr_mem[rd_ptr_reg];
   assign dec_addr  = addr_mem[rd_ptr_reg];
   assign mem_req   = mem_req_reg;
   assign mem_addr  = mem_addr_reg;
   assign count     = count_reg;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         mem_req_reg  <= 1'b0;
         mem_addr_reg <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         if (issue) begin
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= ip_addr;
         end else if (state_reg != IDLE && mem_ack) begin
            mem_req_reg  <= 1'b0;
         end

         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
               2'b10:   count_reg <= count_reg + CW'(1);
               2'b01:   count_reg <= count_reg - CW'(1);
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge Clk) begin
         if (push && wr_ptr_reg == PW'(gi)) begin
            instr_mem[gi] <= mem_rdata;
            addr_mem[gi]  <= mem_addr_reg;
         end
      end
   end

endmodule

// File: doc/ip_prefetch_queue.md
Name: ip_prefetch_queue

Overview:
Instruction prefetch stage directly downstream of the 32-bit instruction-pointer register. It samples the IP value, issues single-word memory reads, and pulses the IP increment strobe on each completed fetch. Fetched words, tagged with their addresses, are buffered in a small FIFO for the decoder. A flush input discards queued and in-flight fetches when the IP is reloaded by a branch (ld) or by interrupt entry (isr).

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
AW, 32, address width (matches IP register)
DW, 32, instruction word width
CW, 3, count width = log2(DEPTH)+1

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-low reset
ip_addr  in  AW  current IP value (IP register Dout)
ip_oe  out  1  output enable to IP register
ip_inc  out  1  one-cycle increment strobe to IP register
flush  in  1  IP being reloaded this cycle (ld or isr); discard everything
mem_req  out  1  read request
mem_addr  out  AW  read address, stable while mem_req=1
mem_ack  in  1  read complete; mem_rdata valid this cycle
mem_rdata  in  DW  read data
dec_valid  out  1  head entry valid
dec_instr  out  DW  head instruction word
dec_addr  out  AW  head instruction address
dec_ready  in  1  decoder accepts head
count  out  CW  FIFO occupancy

Behaviour:
- Reset: sampled on a rising Clk edge while Reset=0. Clears state to IDLE, mem_req=0, mem_addr=0, FIFO pointers=0, count=0, dec_valid=0, ip_inc=0, ip_oe=1. Reset overrides every other input. A fetch in flight when reset is applied is abandoned, and its later mem_ack is ignored while in IDLE.
- FSM states: IDLE, REQ, DISCARD. At most one request is outstanding.
- IDLE:
  - ip_oe=1.
  - If flush=0 and count<DEPTH: mem_addr<=ip_addr, mem_req<=1, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - ip_oe=0; mem_req and mem_addr hold until mem_ack.
  - mem_ack=1, flush=0: push {mem_addr, mem_rdata}, drive ip_inc=1 combinationally in this cycle (IP advances on the same edge), mem_req<=0, go to IDLE.
  - mem_ack=1, flush=1: drop the data, ip_inc=0, mem_req<=0, go to IDLE.
  - mem_ack=0, flush=1: go to DISCARD with mem_req held.
- DISCARD:
  - ip_oe=0; mem_req held until mem_ack. The returned data is dropped and ip_inc=0. Then mem_req<=0 and go to IDLE.
  - Further flushes while in DISCARD have no additional effect.
- ip_inc is only ever asserted in REQ on an accepted ack with flush=0. It is never asserted in a flush cycle, so inc never collides with ld or isr at the IP register.
- Space guarantee: a request is issued only when count<DEPTH. Pops cannot reduce free space, so a push can never overflow.
- FIFO outputs:
  - dec_valid = (count!=0).
  - dec_instr and dec_addr show the head entry combinationally; their value is don't-care when dec_valid=0.
- Pop condition: dec_valid & dec_ready & ~flush. Popping increments the read pointer.
- Push and pop in the same cycle leave count unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Flush:
  - Next cycle: read pointer, write pointer and count are 0, so dec_valid=0.
  - A push or pop in the flush cycle is suppressed.
- Latency:
  - IDLE to mem_req is 1 cycle.
  - A mem_ack arriving on cycle N makes dec_valid=1 on cycle N+1 if the FIFO was empty.
  - The next request issues on cycle N+2, using the already-incremented IP.
- mem_ack is ignored in IDLE.

Test Plan:
- Reset then steady fetch: Reset=0 for 2 cycles then 1, ip_addr=0x0, mem_ack one cycle after each mem_req, dec_ready=1 -> mem_addr sequence 0x0,0x1,0x2 as IP increments; one ip_inc pulse per ack; dec_addr 0x0,0x1,0x2 in order, each with the matching dec_instr.
- Fill to full: dec_ready=0, 4 acks with data 0xA0..0xA3 -> count=4, no fifth mem_req, ip_addr held at 0x4. Then dec_ready=1 for one cycle -> pop of 0xA0, count=3, a new request to 0x4 in the following cycle.
- Flush with request pending: state REQ at 0x10, flush=1, mem_ack two cycles later with 0xDEAD -> mem_req stays high until ack, ip_inc never asserts, count=0, dec_valid=0, then a new request to the reloaded ip_addr=0x3FF.
- Flush coincident with ack: flush=1 and mem_ack=1 in the same cycle, FIFO holding 2 entries -> no push, ip_inc=0, count=0 next cycle, next mem_addr=new ip_addr.
- Simultaneous push/pop with wrap: count=2, write pointer at 3, ack plus pop in the same cycle, repeated 3 times -> count stays 2, write pointer wraps 3->0->1->2, FIFO order preserved.
- Reset mid-fetch: Reset=0 while in REQ -> next cycle mem_req=0, count=0, state IDLE; a stale mem_ack arriving afterwards pushes nothing and produces no ip_inc.
